// File: rtl/pwm_pkg.sv
// Shared types and default sizes for the LED PWM fade controller.
package pwm_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RAMP    = 2'd1,
        BREATHE = 2'd2,
        OFF     = 2'd3
    } pwm_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP_S = 2'd1,
        BR_UP  = 2'd2,
        BR_DN  = 2'd3
    } fade_state_t;

    localparam int CBITS_DEF    = 15;
    localparam int DBITS_DEF    = 4;
    localparam int STEP_DIV_DEF = 256;

endpackage

// File: rtl/pwm_core.sv
// Free-running PWM counter with registered compare output and end-of-period strobe.
module pwm_core
    import pwm_pkg::*;
#(
    parameter int CBITS = CBITS_DEF,
    parameter int DBITS = DBITS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DBITS-1:0] duty,
    output logic             pulse,
    output logic             period_tick
);

    localparam logic [CBITS-1:0] CNT_PRE = {{(CBITS-1){1'b1}}, 1'b0};

    logic [CBITS-1:0] cnt;
    logic [CBITS-1:0] thr;

    assign thr = {duty, {(CBITS-DBITS){1'b0}}};

    // period_tick is registered one count early so it is high while cnt is all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            pulse       <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            cnt         <= cnt + CBITS'(1);
            pulse       <= (cnt < thr);
            period_tick <= (cnt == CNT_PRE);
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty sequencer (hold / ramp / breathe / off) driving one PWM channel.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int CBITS    = CBITS_DEF,
    parameter int DBITS    = DBITS_DEF,
    parameter int STEP_DIV = STEP_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [DBITS-1:0] cfg_target,
    output logic             pulse_out,
    output logic [DBITS-1:0] duty_cur,
    output logic             busy,
    output logic             period_tick
);

    localparam int             SW        = $clog2(STEP_DIV) + 1;
    localparam logic [SW-1:0]  STEP_LAST = SW'(STEP_DIV - 1);

    fade_state_t      state, state_nx;
    pwm_mode_t        mode_q, mode_nx, cmd;
    logic [DBITS-1:0] target_q, target_nx, duty_nx;
    logic [SW-1:0]    step_cnt, step_nx;
    logic             pend, pend_nx;
    logic             accept;

    // A command transfers on any cycle where cfg_valid and cfg_ready are both high;
    // cfg_valid may be held across cycles and cfg_ready is low only while ramping.
    assign accept = cfg_valid & cfg_ready;
    assign cmd    = pwm_mode_t'(cfg_mode);

    always_comb begin
        state_nx  = state;
        duty_nx   = duty_cur;
        pend_nx   = pend;
        step_nx   = step_cnt;
        target_nx = target_q;
        mode_nx   = mode_q;
        if (accept) begin
            // An accept always wins over a coincident step; any duty change waits a tick.
            mode_nx   = cmd;
            target_nx = cfg_target;
            step_nx   = '0;
            pend_nx   = 1'b0;
            case (cmd)
                HOLD, OFF: begin
                    state_nx = IDLE;
                    pend_nx  = 1'b1;
                end
                RAMP: state_nx = (cfg_target == duty_cur) ? IDLE : RAMP_S;
                default: begin
                    if (cfg_target == '0) begin
                        state_nx = IDLE;
                        pend_nx  = 1'b1;
                    end else begin
                        state_nx = BR_UP;
                    end
                end
            endcase
        end else if (period_tick) begin
            if (state == IDLE) begin
                if (pend) begin
                    duty_nx = (mode_q == OFF) ? '0 : target_q;
                    pend_nx = 1'b0;
                end
            end else if (step_cnt != STEP_LAST) begin
                step_nx = step_cnt + SW'(1);
            end else begin
                step_nx = '0;
                case (state)
                    RAMP_S: begin
                        if (duty_cur < target_q)
                            duty_nx = duty_cur + DBITS'(1);
                        else if (duty_cur > target_q)
                            duty_nx = duty_cur - DBITS'(1);
                        if (duty_nx == target_q)
                            state_nx = IDLE;
                    end
                    BR_UP: begin
                        // Clamp when a retargeted breathe starts above its new peak.
                        if (duty_cur >= target_q) begin
                            duty_nx  = target_q;
                            state_nx = BR_DN;
                        end else begin
                            duty_nx = duty_cur + DBITS'(1);
                            if (duty_nx == target_q)
                                state_nx = BR_DN;
                        end
                    end
                    BR_DN: begin
                        if (duty_cur != '0)
                            duty_nx = duty_cur - DBITS'(1);
                        if (duty_nx == '0)
                            state_nx = BR_UP;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= HOLD;
            target_q  <= '0;
            duty_cur  <= '0;
            step_cnt  <= '0;
            pend      <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            state     <= state_nx;
            mode_q    <= mode_nx;
            target_q  <= target_nx;
            duty_cur  <= duty_nx;
            step_cnt  <= step_nx;
            pend      <= pend_nx;
            busy      <= (state_nx != IDLE);
            cfg_ready <= (state_nx != RAMP_S);
        end
    end

    pwm_core #(
        .CBITS (CBITS),
        .DBITS (DBITS)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .duty        (duty_cur),
        .pulse       (pulse_out),
        .period_tick (period_tick)
    );

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl with a duty-change scoreboard and a PWM reference model.
module tb_pwm_fade_ctrl;
    import pwm_pkg::*;

    localparam int CBITS    = 8;
    localparam int DBITS    = 4;
    localparam int STEP_DIV = 2;
    localparam int W        = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_mode = 2'd0;
    logic [3:0] cfg_target = 4'd0;
    logic       cfg_ready;
    logic       pulse_out;
    logic [3:0] duty_cur;
    logic       busy;
    logic       period_tick;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] item;
    logic [7:0]   tb_cnt;
    logic [15:0]  tick_cnt;
    logic         pulse_exp;
    logic [3:0]   duty_model;
    logic [3:0]   last_duty;

    pwm_fade_ctrl #(
        .CBITS    (CBITS),
        .DBITS    (DBITS),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_mode    (cfg_mode),
        .cfg_target  (cfg_target),
        .pulse_out   (pulse_out),
        .duty_cur    (duty_cur),
        .busy        (busy),
        .period_tick (period_tick)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference counter, tick counter and PWM output model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_cnt    <= 8'd0;
            tick_cnt  <= 16'd0;
            pulse_exp <= 1'b0;
        end else begin
            tb_cnt    <= tb_cnt + 8'd1;
            if (tb_cnt == 8'hFF)
                tick_cnt <= tick_cnt + 16'd1;
            pulse_exp <= (tb_cnt < {duty_model, 4'b0000});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            duty_model = 4'd0;
            last_duty  = 4'd0;
        end else begin
            chk("period_tick", {31'd0, period_tick}, {31'd0, tb_cnt == 8'hFF});
            chk("pulse_out", {31'd0, pulse_out}, {31'd0, pulse_exp});
            if (duty_cur !== last_duty) begin
                chk("duty_at_boundary", {24'd0, tb_cnt}, 32'd0);
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL duty_unexpected: got %0d expected no change from %0d", duty_cur, last_duty);
                end
                if (exp_q.size() > 0) begin
                    item = exp_q.pop_front();
                    chk("duty_value", {28'd0, duty_cur}, {28'd0, item[3:0]});
                    chk("duty_tick", {16'd0, tick_cnt}, {16'd0, item[19:4]});
                    duty_model = item[3:0];
                end
                last_duty = duty_cur;
            end
        end
    end

    // driver tasks
    task automatic push_exp(input int tk, input int d);
        exp_q.push_back({tk[15:0], d[3:0]});
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_cnt(input int v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (tb_cnt == v[7:0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_cnt_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic send(input pwm_mode_t mode, input int target, input int budget, output int t_acc);
        bit ok;
        ok    = 1'b0;
        t_acc = 0;
        @(negedge clk);
        cfg_mode   = mode;
        cfg_target = target[3:0];
        cfg_valid  = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (cfg_ready === 1'b1) begin
                t_acc = int'(tick_cnt);
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic count_high(input string tag, input int exp);
        int hi;
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pulse_out === 1'b1)
                hi++;
        end
        chk(tag, hi, exp);
    endtask

    initial begin
        int t;
        int t2;
        bit ok;

        // 1: reset values, then HOLD 8
        do_reset();
        @(negedge clk);
        chk("rst_pulse", {31'd0, pulse_out}, 32'd0);
        chk("rst_duty", {28'd0, duty_cur}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tick", {31'd0, period_tick}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        wait_cnt(100);
        send(HOLD, 8, 10, t);
        push_exp(t + 1, 8);
        chk("hold_duty_pending", {28'd0, duty_cur}, 32'd0);
        wait_drain(600);
        wait_cnt(10);
        count_high("hold8_high_count", 128);

        // 2: RAMP 0 -> 3
        do_reset();
        wait_cnt(100);
        send(RAMP, 3, 10, t);
        for (int k = 1; k <= 3; k++)
            push_exp(t + 2 * k, k);
        chk("ramp_busy_start", {31'd0, busy}, 32'd1);
        chk("ramp_ready_start", {31'd0, cfg_ready}, 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (duty_cur === 4'd3) begin
                ok = 1'b1;
                break;
            end
            chk("ramp_ready_low", {31'd0, cfg_ready}, 32'd0);
            chk("ramp_busy_high", {31'd0, busy}, 32'd1);
        end
        chk("ramp_reach_timeout", {31'd0, ok}, 32'd1);
        chk("ramp_busy_fall", {31'd0, busy}, 32'd0);
        chk("ramp_ready_rise", {31'd0, cfg_ready}, 32'd1);
        chk("ramp_fall_at_tick", {24'd0, tb_cnt}, 32'd0);
        wait_drain(600);

        // 3: BREATHE peak 2
        do_reset();
        wait_cnt(100);
        send(BREATHE, 2, 10, t);
        push_exp(t + 2, 1);
        push_exp(t + 4, 2);
        push_exp(t + 6, 1);
        push_exp(t + 8, 0);
        push_exp(t + 10, 1);
        push_exp(t + 12, 2);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            chk("breathe_ready", {31'd0, cfg_ready}, 32'd1);
            chk("breathe_busy", {31'd0, busy}, 32'd1);
        end
        chk("breathe_timeout", {31'd0, ok}, 32'd1);

        // 4: OFF during BREATHE, mid-period
        wait_cnt(60);
        send(OFF, 0, 10, t);
        chk("off_duty_unchanged", {28'd0, duty_cur}, 32'd2);
        push_exp(t + 1, 0);
        wait_drain(600);
        chk("off_busy", {31'd0, busy}, 32'd0);
        wait_cnt(10);
        count_high("off_high_count", 0);

        // 5: HOLD held off while RAMP 0 -> 15 runs
        do_reset();
        wait_cnt(100);
        send(RAMP, 15, 10, t);
        for (int k = 1; k <= 15; k++)
            push_exp(t + 2 * k, k);
        send(HOLD, 4, 9000, t2);
        chk("hold_accept_tick", t2, t + 30);
        chk("hold_accept_duty", {28'd0, duty_cur}, 32'd15);
        chk("hold_accept_queue", exp_q.size(), 32'd0);
        push_exp(t2 + 1, 4);
        wait_drain(600);

        // 6: asynchronous reset mid-RAMP at duty 5
        do_reset();
        wait_cnt(100);
        send(RAMP, 15, 10, t);
        for (int k = 1; k <= 15; k++)
            push_exp(t + 2 * k, k);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 10) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ramp5_timeout", {31'd0, ok}, 32'd1);
        wait_cnt(20);
        #2;
        chk("pre_reset_pulse", {31'd0, pulse_out}, 32'd1);
        chk("pre_reset_duty", {28'd0, duty_cur}, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("async_rst_pulse", {31'd0, pulse_out}, 32'd0);
        chk("async_rst_duty", {28'd0, duty_cur}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_ready", {31'd0, cfg_ready}, 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        chk("post_rst_duty", {28'd0, duty_cur}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
